// File: rtl/escalonador_quantum.sv
// escalonador_quantum: round-robin process scheduler with a per-slice quantum timer.
//
// Keeps NUM_PROC process slots, each with a state (LIVRE/PRONTO/EXECUTANDO/BLOQUEADO)
// and a saved PC. The FSM (IDLE -> SELECT -> RUN) picks the next ready process
// round-robin, tells the core to switch context and saves the outgoing PC on
// termination, I/O blocking or quantum expiry.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   start               leave IDLE and begin scheduling
//   enable              one instruction retired by the running process
//   pc_atual            next PC of the running process
//   proc_load*          register a new process into a free slot
//   instr_io            running process issued an I/O instruction
//   fim_processo        running process terminated
//   io_done, io_done_id I/O completion for a blocked process
//   troca_contexto      one-cycle pulse: core loads pc_novo
//   pc_novo             resume PC of the selected process
//   pc_salvo            PC saved for the outgoing process
//   processo_atual      id of the running/selected process (also the search pointer)
//   ocioso              no ready process, core must stall
//   ativos              bit i set when slot i is not LIVRE
module escalonador_quantum #(
    parameter int unsigned NUM_PROC = 4,
    parameter int unsigned PID_W    = 2,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned QUANTUM  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                enable,
    input  logic [PC_WIDTH-1:0] pc_atual,
    input  logic                proc_load,
    input  logic [PID_W-1:0]    proc_load_id,
    input  logic [PC_WIDTH-1:0] proc_load_pc,
    input  logic                instr_io,
    input  logic                fim_processo,
    input  logic                io_done,
    input  logic [PID_W-1:0]    io_done_id,
    output logic                troca_contexto,
    output logic [PC_WIDTH-1:0] pc_novo,
    output logic [PC_WIDTH-1:0] pc_salvo,
    output logic [PID_W-1:0]    processo_atual,
    output logic                ocioso,
    output logic [NUM_PROC-1:0] ativos
);

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] QuantumLast = CntW'(QUANTUM - 1);

    typedef enum logic [1:0] {Livre, Pronto, Executando, Bloqueado} slot_e;
    typedef enum logic [1:0] {StIdle, StSelect, StRun} fsm_e;

    fsm_e                fsm_q, fsm_d;
    slot_e               slot_estado_q [NUM_PROC];
    slot_e               slot_estado_d [NUM_PROC];
    logic [PC_WIDTH-1:0] slot_pc_q [NUM_PROC];
    logic [PC_WIDTH-1:0] slot_pc_d [NUM_PROC];
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                troca_q, troca_d;
    logic [PC_WIDTH-1:0] pc_novo_q, pc_novo_d;
    logic [PC_WIDTH-1:0] pc_salvo_q, pc_salvo_d;
    logic [PID_W-1:0]    atual_q, atual_d;
    logic                ocioso_q, ocioso_d;

    logic                found;
    logic [PID_W-1:0]    sel_id;
    logic [PID_W-1:0]    cand;
    logic                expira;

    // Round-robin scan starting just after the current id; current id is checked last.
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        cand   = '0;
        for (int k = 1; k <= int'(NUM_PROC); k++) begin
            cand = PID_W'((int'(atual_q) + k) % int'(NUM_PROC));
            if (!found && slot_estado_q[cand] == Pronto) begin
                found  = 1'b1;
                sel_id = cand;
            end
        end
    end

    always_comb begin
        fsm_d         = fsm_q;
        slot_estado_d = slot_estado_q;
        slot_pc_d     = slot_pc_q;
        cnt_d         = cnt_q;
        troca_d       = 1'b0;
        pc_novo_d     = pc_novo_q;
        pc_salvo_d    = pc_salvo_q;
        atual_d       = atual_q;
        ocioso_d      = ocioso_q;
        expira        = 1'b0;

        // Loads and wake-ups only touch LIVRE/BLOQUEADO slots, while the FSM only
        // touches PRONTO/EXECUTANDO ones, so the writes below never collide.
        if (proc_load && (32'(proc_load_id) < NUM_PROC)
            && slot_estado_q[proc_load_id] == Livre) begin
            slot_estado_d[proc_load_id] = Pronto;
            slot_pc_d[proc_load_id]     = proc_load_pc;
        end
        if (io_done && (32'(io_done_id) < NUM_PROC)
            && slot_estado_q[io_done_id] == Bloqueado) begin
            slot_estado_d[io_done_id] = Pronto;
        end

        unique case (fsm_q)
            StIdle: begin
                if (start) begin
                    fsm_d   = StSelect;
                    atual_d = PID_W'(NUM_PROC - 1);
                end
            end
            StSelect: begin
                if (found) begin
                    slot_estado_d[sel_id] = Executando;
                    atual_d               = sel_id;
                    pc_novo_d             = slot_pc_q[sel_id];
                    troca_d               = 1'b1;
                    cnt_d                 = '0;
                    ocioso_d              = 1'b0;
                    fsm_d                 = StRun;
                end else begin
                    ocioso_d = 1'b1;
                end
            end
            StRun: begin
                expira = enable && (cnt_q == QuantumLast);
                if (enable) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (fim_processo || instr_io || expira) begin
                    pc_salvo_d         = pc_atual;
                    slot_pc_d[atual_q] = pc_atual;
                    fsm_d              = StSelect;
                    if (fim_processo) begin
                        slot_estado_d[atual_q] = Livre;
                    end else if (instr_io) begin
                        slot_estado_d[atual_q] = Bloqueado;
                    end else begin
                        slot_estado_d[atual_q] = Pronto;
                    end
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q      <= StIdle;
            cnt_q      <= '0;
            troca_q    <= 1'b0;
            pc_novo_q  <= '0;
            pc_salvo_q <= '0;
            atual_q    <= '0;
            ocioso_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_PROC); i++) begin
                slot_estado_q[i] <= Livre;
                slot_pc_q[i]     <= '0;
            end
        end else begin
            fsm_q         <= fsm_d;
            cnt_q         <= cnt_d;
            troca_q       <= troca_d;
            pc_novo_q     <= pc_novo_d;
            pc_salvo_q    <= pc_salvo_d;
            atual_q       <= atual_d;
            ocioso_q      <= ocioso_d;
            slot_estado_q <= slot_estado_d;
            slot_pc_q     <= slot_pc_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_PROC); i++) begin
            ativos[i] = (slot_estado_q[i] != Livre);
        end
    end

    assign troca_contexto = troca_q;
    assign pc_novo        = pc_novo_q;
    assign pc_salvo       = pc_salvo_q;
    assign processo_atual = atual_q;
    assign ocioso         = ocioso_q;

endmodule

// File: tb/tb_escalonador_quantum.sv
// Self-checking bench for escalonador_quantum: directed scenarios followed by
// random stimulus, every cycle compared against a behavioural scheduler model.
module tb_escalonador_quantum;

    localparam int NP = 4;
    localparam int PW = 2;
    localparam int PCW = 32;
    localparam int Q = 16;

    localparam int LIVRE = 0;
    localparam int PRONTO = 1;
    localparam int EXEC = 2;
    localparam int BLOQ = 3;

    logic           clock = 1'b0;
    logic           reset, start, enable, proc_load, instr_io, fim_processo, io_done;
    logic [PCW-1:0] pc_atual, proc_load_pc;
    logic [PW-1:0]  proc_load_id, io_done_id;
    logic           troca_contexto, ocioso;
    logic [PCW-1:0] pc_novo, pc_salvo;
    logic [PW-1:0]  processo_atual;
    logic [NP-1:0]  ativos;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model state
    int          m_fsm;   // 0 idle, 1 select, 2 run
    int          m_slot [NP];
    logic [31:0] m_spc [NP];
    int          m_atual, m_cnt;
    logic        m_troca, m_ocioso;
    logic [31:0] m_pc_novo, m_pc_salvo;

    escalonador_quantum #(
        .NUM_PROC(NP), .PID_W(PW), .PC_WIDTH(PCW), .QUANTUM(Q)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .enable(enable),
        .pc_atual(pc_atual), .proc_load(proc_load), .proc_load_id(proc_load_id),
        .proc_load_pc(proc_load_pc), .instr_io(instr_io), .fim_processo(fim_processo),
        .io_done(io_done), .io_done_id(io_done_id), .troca_contexto(troca_contexto),
        .pc_novo(pc_novo), .pc_salvo(pc_salvo), .processo_atual(processo_atual),
        .ocioso(ocioso), .ativos(ativos)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fsm = 0; m_atual = 0; m_cnt = 0;
        m_troca = 0; m_ocioso = 0; m_pc_novo = 0; m_pc_salvo = 0;
        for (int i = 0; i < NP; i++) begin
            m_slot[i] = LIVRE;
            m_spc[i]  = 0;
        end
    endtask

    // Applies the scheduling rules for one rising edge using the current inputs.
    task automatic model_step();
        int  old [NP];
        int  pick;
        int  id;
        bit  quantum_end;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NP; i++) old[i] = m_slot[i];
        m_troca = 0;
        if (m_fsm == 0) begin
            if (start) begin
                m_fsm = 1;
                m_atual = NP - 1;
            end
        end else if (m_fsm == 1) begin
            pick = -1;
            for (int k = 1; k <= NP; k++) begin
                id = (m_atual + k) % NP;
                if (pick < 0 && old[id] == PRONTO) pick = id;
            end
            if (pick >= 0) begin
                m_slot[pick] = EXEC;
                m_atual = pick;
                m_pc_novo = m_spc[pick];
                m_troca = 1;
                m_cnt = 0;
                m_ocioso = 0;
                m_fsm = 2;
            end else begin
                m_ocioso = 1;
            end
        end else begin
            quantum_end = enable && (m_cnt == Q - 1);
            if (enable) m_cnt++;
            if (fim_processo || instr_io || quantum_end) begin
                m_pc_salvo = pc_atual;
                m_spc[m_atual] = pc_atual;
                m_fsm = 1;
                m_slot[m_atual] = fim_processo ? LIVRE : (instr_io ? BLOQ : PRONTO);
            end
        end
        if (proc_load && old[proc_load_id] == LIVRE) begin
            m_slot[proc_load_id] = PRONTO;
            m_spc[proc_load_id] = proc_load_pc;
        end
        if (io_done && old[io_done_id] == BLOQ) m_slot[io_done_id] = PRONTO;
    endtask

    task automatic compare_all();
        logic [NP-1:0] exp_at;
        for (int i = 0; i < NP; i++) exp_at[i] = (m_slot[i] != LIVRE);
        check("troca_contexto", troca_contexto, m_troca);
        check("pc_novo", pc_novo, m_pc_novo);
        check("pc_salvo", pc_salvo, m_pc_salvo);
        check("processo_atual", processo_atual, m_atual[PW-1:0]);
        check("ocioso", ocioso, m_ocioso);
        check("ativos", ativos, exp_at);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; enable = 0; proc_load = 0; instr_io = 0;
        fim_processo = 0; io_done = 0; pc_atual = 0; proc_load_pc = 0;
        proc_load_id = 0; io_done_id = 0;
    endtask

    task automatic load(input int id, input logic [31:0] pc);
        proc_load = 1; proc_load_id = PW'(id); proc_load_pc = pc;
        tick();
        proc_load = 0;
    endtask

    task automatic run_quantum(input logic [31:0] pc);
        enable = 1; pc_atual = pc;
        for (int i = 0; i < Q; i++) tick();
        enable = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        check("rst_ativos", ativos, 0);
        check("rst_troca", troca_contexto, 0);

        // Two processes, first quantum expiry
        load(0, 100);
        load(1, 200);
        start = 1; tick(); start = 0;
        tick();
        check("first_troca", troca_contexto, 1);
        check("first_id", processo_atual, 0);
        check("first_pc", pc_novo, 100);
        run_quantum(116);
        check("q_pc_salvo", pc_salvo, 116);
        tick();
        check("sw1_troca", troca_contexto, 1);
        check("sw1_id", processo_atual, 1);
        check("sw1_pc", pc_novo, 200);

        // Process 1 blocks on I/O, later resumes at its saved PC
        instr_io = 1; pc_atual = 205; tick(); instr_io = 0;
        tick();
        check("io_sw_id", processo_atual, 0);
        check("io_sw_pc", pc_novo, 116);
        check("io_blocked_ativo", ativos[1], 1);
        io_done = 1; io_done_id = 1; tick(); io_done = 0;
        run_quantum(130);
        tick();
        check("resume_id", processo_atual, 1);
        check("resume_pc", pc_novo, 205);

        // Slot 1 ends; slot 0 is alone and gets reselected on expiry
        fim_processo = 1; pc_atual = 300; tick(); fim_processo = 0;
        tick();
        check("alone_id", processo_atual, 0);
        run_quantum(140);
        tick();
        check("resel_troca", troca_contexto, 1);
        check("resel_id", processo_atual, 0);
        check("resel_pc", pc_novo, 140);

        // Sole process blocks: stall, then wake up
        instr_io = 1; pc_atual = 150; tick(); instr_io = 0;
        tick();
        check("stall_ocioso", ocioso, 1);
        check("stall_troca", troca_contexto, 0);
        io_done = 1; io_done_id = 0; tick(); io_done = 0;
        check("stall2_ocioso", ocioso, 1);
        tick();
        check("wake_ocioso", ocioso, 0);
        check("wake_troca", troca_contexto, 1);
        check("wake_pc", pc_novo, 150);

        // fim_processo wins over instr_io; reload of busy slot ignored
        fim_processo = 1; instr_io = 1; pc_atual = 160; tick();
        fim_processo = 0; instr_io = 0;
        check("fim_ativos", ativos, 0);
        load(2, 400);
        load(2, 999);
        check("busy_load_pc", pc_novo, 400);
        check("busy_load_id", processo_atual, 2);

        // Reset during SELECT, then enables without start
        fim_processo = 1; pc_atual = 410; tick(); fim_processo = 0;
        reset = 1; tick(); reset = 0;
        check("rs_ativos", ativos, 0);
        check("rs_id", processo_atual, 0);
        enable = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("nostart_troca", troca_contexto, 0);
        end
        enable = 0;

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            reset        = ($urandom_range(0, 199) == 0);
            start        = ($urandom_range(0, 7) == 0);
            enable       = $urandom_range(0, 1) == 1;
            pc_atual     = $urandom;
            proc_load    = ($urandom_range(0, 5) == 0);
            proc_load_id = PW'($urandom_range(0, NP - 1));
            proc_load_pc = $urandom;
            instr_io     = ($urandom_range(0, 19) == 0);
            fim_processo = ($urandom_range(0, 29) == 0);
            io_done      = ($urandom_range(0, 4) == 0);
            io_done_id   = PW'($urandom_range(0, NP - 1));
            tick();
        end
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
